// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch stage (in: clk reset_n stall redirect_valid redirect_target halt imem_instr; out: imem_addr if_pc if_instr if_valid fetch_count)
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic [CNT_W-1:0]  fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, next_state;
  logic [ADDR_W-1:0] pc_q, next_pc;
  always_comb begin
    next_state = ((state == HALT || (state == RUN && halt)) && !redirect_valid) ? HALT : RUN;
    next_pc = redirect_valid ? redirect_target :
              state == BOOT ? RESET_PC :
              (state == RUN && !halt && !stall) ? pc_q + 1'b1 : pc_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      pc_q <= RESET_PC;
      if_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= next_state;
      pc_q <= next_pc;
      if_valid <= next_state == RUN;
      fetch_count <= fetch_count + CNT_W'(if_valid && !stall);
    end
  end
  assign imem_addr = next_pc;
  assign if_pc = pc_q;
  assign if_instr = imem_instr;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam int AW = 12;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stall = 1'b0;
  logic redirect_valid = 1'b0;
  logic halt = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic [AW-1:0] imem_addr, if_pc;
  logic [31:0] imem_instr, if_instr;
  logic if_valid;
  logic [CW-1:0] fetch_count;
  always #5 clk = ~clk;
  fetch_unit #(.ADDR_W(AW), .RESET_PC('0), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt(halt), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .if_pc(if_pc), .if_instr(if_instr),
    .if_valid(if_valid), .fetch_count(fetch_count)
  );
  function automatic logic [31:0] memw(input logic [AW-1:0] a);
    return {4'hC, a, 4'h5, ~a};
  endfunction
  always_ff @(posedge clk) imem_instr <= memw(imem_addr);
  typedef struct {logic s; logic rv; logic [AW-1:0] tgt; logic h; logic [AW-1:0] pc; logic v;} vec_t;
  typedef struct {logic [AW-1:0] pc; logic v; logic [31:0] instr; logic [CW-1:0] cnt;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic s, input logic rv, input int tgt, input logic h, input int pc, input logic v);
    vec_t t;
    t.s = s; t.rv = rv; t.tgt = tgt[AW-1:0]; t.h = h; t.pc = pc[AW-1:0]; t.v = v;
    tbl.push_back(t);
  endtask
  initial begin
    logic prev_v;
    logic [CW-1:0] cnt;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_fetch_count", 64'(fetch_count), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 chk("boot_if_valid", 64'(if_valid), 64'd0);
    for (int i = 0; i <= 5; i++) add(0, 0, 0, 0, i, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 5, 1);
    for (int i = 6; i <= 10; i++) add(0, 0, 0, 0, i, 1);
    add(1, 1, 'h200, 0, 'h200, 1);
    add(0, 0, 0, 0, 'h201, 1);
    add(0, 1, 4094, 0, 4094, 1);
    add(0, 0, 0, 0, 4095, 1);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 1, 20, 0, 20, 1);
    add(0, 0, 0, 1, 20, 0);
    for (int i = 0; i < 10; i++) add(i[0], 0, 0, 0, 20, 0);
    add(0, 1, 'h40, 0, 'h40, 1);
    add(0, 0, 0, 0, 'h41, 1);
    add(0, 1, 'h80, 1, 'h80, 1);
    add(0, 0, 0, 1, 'h80, 0);
    add(0, 1, 'h90, 1, 'h90, 1);
    add(0, 0, 0, 0, 'h91, 1);
    prev_v = 1'b0;
    cnt = '0;
    foreach (tbl[i]) begin
      @(negedge clk);
      stall = tbl[i].s;
      redirect_valid = tbl[i].rv;
      redirect_target = tbl[i].tgt;
      halt = tbl[i].h;
      if (prev_v && !tbl[i].s) cnt++;
      sb.push_back('{pc: tbl[i].pc, v: tbl[i].v, instr: memw(tbl[i].pc), cnt: cnt});
      prev_v = tbl[i].v;
      #1 chk($sformatf("imem_addr[%0d]", i), 64'(imem_addr), 64'(tbl[i].pc));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("if_pc[%0d]", i), 64'(if_pc), 64'(e.pc));
      chk($sformatf("if_valid[%0d]", i), 64'(if_valid), 64'(e.v));
      chk($sformatf("if_instr[%0d]", i), 64'(if_instr), 64'(e.instr));
      chk($sformatf("fetch_count[%0d]", i), 64'(fetch_count), 64'(e.cnt));
    end
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    reset_n = 1'b0;
    #1 chk("async_rst_count", 64'(fetch_count), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (101) @(posedge clk);
    #1;
    chk("run_count", 64'(fetch_count), 64'd100);
    chk("run_pc", 64'(if_pc), 64'd100);
    chk("run_valid", 64'(if_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(fetch_count), 64'd0);
    chk("mid_rst_valid", 64'(if_valid), 64'd0);
    chk("mid_rst_pc", 64'(if_pc), 64'd0);
    chk("mid_rst_addr", 64'(imem_addr), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory word address combinationally, so the memory's registered read returns the instruction for the PC the unit holds in the following cycle. It pairs each returned instruction with its PC and a valid flag for decode. It also handles stall, branch/jump redirect, halt, and a delivered-instruction counter.

Parameters:
ADDR_W, 12, word-address width; must match the instruction memory address width.
RESET_PC, 0, first word address fetched after reset.
CNT_W, 32, width of the delivered-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset_n  in  1  asynchronous active-low reset. Integration inverts it for the memory's active-high reset.
stall  in  1  decode cannot accept; hold the current PC/instruction.
redirect_valid  in  1  branch/jump/trap taken this cycle.
redirect_target  in  ADDR_W  word address to fetch on redirect.
halt  in  1  stop fetching (ebreak/ecall from execute).
imem_addr  out  ADDR_W  combinational word address to instruction memory.
imem_instr  in  32  registered instruction memory output.
if_pc  out  ADDR_W  PC of the instruction currently on if_instr.
if_instr  out  32  equals imem_instr; combinational passthrough.
if_valid  out  1  if_pc/if_instr pair is a real fetched instruction.
fetch_count  out  CNT_W  number of instructions accepted by decode.

Behaviour:
- Reset is asynchronous on reset_n low, all registers:
  - state = BOOT, pc_q = RESET_PC, if_valid = 0, fetch_count = 0.
  - Outputs while reset is held: if_pc = RESET_PC, if_valid = 0, imem_addr = RESET_PC.
- States: BOOT, RUN, HALT (2-bit encoding).
- next_pc, combinational. Priority is redirect > halt > stall > sequential:
  - BOOT: RESET_PC, unless redirect_valid, then redirect_target.
  - RUN:
    - redirect_valid → redirect_target.
    - else halt → pc_q.
    - else stall → pc_q.
    - else pc_q + 1, modulo 2^ADDR_W (4095 wraps to 0).
  - HALT: redirect_valid ? redirect_target : pc_q.
- imem_addr = next_pc at all times. The memory samples it on the same edge that loads pc_q <= next_pc, so at every cycle imem_instr corresponds to pc_q. Latency from address to if_valid is 1 cycle.
- State transitions, each on a rising edge:
  - BOOT → RUN on the first edge after reset deasserts, unconditionally. The first cycle out of reset always has if_valid = 0.
  - RUN → HALT when halt=1 and redirect_valid=0.
  - HALT → RUN on redirect_valid=1.
  - HALT is otherwise sticky; stall has no effect in HALT.
- if_valid register, loaded each edge:
  - 1 when the next state is RUN.
  - 0 when the next state is BOOT or HALT.
- Stall in RUN: pc_q and imem_addr are unchanged, the memory re-reads the same word, and if_pc/if_instr/if_valid stay stable for as many cycles as stall stays high.
- Redirect while stall=1: redirect wins, and the target instruction appears the next cycle with if_valid=1. Decode is responsible for squashing the in-flight instruction.
- Redirect and halt in the same cycle: redirect wins and the state stays or becomes RUN.
- fetch_count increments by 1 on an edge where if_valid=1 and stall=0, i.e. decode accepted. It wraps modulo 2^CNT_W and is unaffected by redirect.
- Reset asserted mid-operation: immediate asynchronous return to reset values. No partial-update glitch on registered outputs.

Test Plan:
- Reset/boot: hold reset_n=0 3 cycles, then release → imem_addr=0 during reset; if_valid=0 on the first cycle after release; then if_pc=0,1,2,3 on consecutive cycles with if_valid=1; if_instr matches memory words 0..3.
- Stall: in RUN at if_pc=5, assert stall for 3 cycles → if_pc=5 and if_instr=mem[5] stable with if_valid=1; fetch_count does not change; after release if_pc=6 the next cycle.
- Redirect: at if_pc=10, pulse redirect_valid with target 0x200 while stall=1 → next cycle if_pc=0x200, if_instr=mem[0x200], if_valid=1; then 0x201.
- Wrap: redirect to 4094, no stall → if_pc sequence 4094, 4095, 0, 1.
- Halt: assert halt at if_pc=20 → next cycle if_valid=0 and if_pc=20, held for 10 cycles even with stall toggling. Redirect to 0x40 → next cycle if_pc=0x40, if_valid=1. Halt and redirect together → RUN at the target.
- Counter/async reset: run 100 unstalled cycles → fetch_count=100. Drop reset_n mid-cycle (not on an edge) → fetch_count=0 and if_valid=0 immediately, before the next clk edge.
